// File: rtl/garbage_arbiter_pkg.sv
// Shared definitions for the versus-mode garbage arbiter.
// Provides counter/offer widths, the line-clear attack table, the channel
// state encoding and small helpers for the hole-column LFSR.
package garbage_arbiter_pkg;

  localparam int unsigned PEND_W = 5;
  localparam int unsigned ROWS_W = 3;
  localparam int unsigned HOLE_W = 4;

  localparam logic [ROWS_W-1:0] ATK_1 = 3'd0;
  localparam logic [ROWS_W-1:0] ATK_2 = 3'd1;
  localparam logic [ROWS_W-1:0] ATK_3 = 3'd2;
  localparam logic [ROWS_W-1:0] ATK_4 = 3'd4;

  typedef enum logic {
    CH_IDLE,
    CH_OFFER
  } ch_state_e;

  // Garbage rows sent for a given number of cleared lines.
  function automatic logic [ROWS_W-1:0] attack_rows(input logic [2:0] lines);
    logic [ROWS_W-1:0] a;
    case (lines)
      3'd1:    a = ATK_1;
      3'd2:    a = ATK_2;
      3'd3:    a = ATK_3;
      3'd4:    a = ATK_4;
      default: a = '0;
    endcase
    return a;
  endfunction

  // 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [HOLE_W-1:0] hole_of(input logic [7:0] s);
    logic [7:0] m;
    m = s % 8'd10;
    return m[HOLE_W-1:0];
  endfunction

endpackage

// File: rtl/garbage_arbiter_channel.sv
// One player's garbage channel: pending-row counter plus IDLE/OFFER FSM.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_step          apply this cycle's cancel/add/lock/ack
//   i_flush         game over: clear pending, drop any offer
//   i_lock, i_ack   piece-lock pulse, offer acknowledge
//   i_cancel        rows cancelled by this player's own clear
//   i_add           rows arriving from the opponent
//   i_hole          hole column to latch if an offer starts this cycle
//   o_valid/o_rows/o_hole  registered offer
//   o_pending       rows owed, including offered rows
//   o_offered       rows currently locked into an offer (0 when idle)
//   o_enter         an offer starts at this edge (drives LFSR stepping)
module garbage_channel
  import garbage_arbiter_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 20,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_lock,
  input  logic              i_ack,
  input  logic [ROWS_W-1:0] i_cancel,
  input  logic [ROWS_W-1:0] i_add,
  input  logic [HOLE_W-1:0] i_hole,
  output logic              o_valid,
  output logic [ROWS_W-1:0] o_rows,
  output logic [HOLE_W-1:0] o_hole,
  output logic [PEND_W-1:0] o_pending,
  output logic [PEND_W-1:0] o_offered,
  output logic              o_enter
);

  localparam int unsigned NW = PEND_W + 1;
  localparam logic [NW-1:0]     LP_MAXP  = NW'(MAX_PENDING);
  localparam logic [PEND_W-1:0] LP_BURST = PEND_W'(MAX_BURST);

  ch_state_e         r_state;
  logic [PEND_W-1:0] r_pending;
  logic [ROWS_W-1:0] r_rows;
  logic [HOLE_W-1:0] r_hole;
  logic              r_valid;

  logic              w_ack_take;
  logic [ROWS_W-1:0] w_ack_rows;
  logic [NW-1:0]     w_net;
  logic [PEND_W-1:0] w_pend_next;
  logic [ROWS_W-1:0] w_burst;
  logic              w_enter;

  // Cancellation never reaches offered rows, so the subtractions cannot wrap;
  // the opponent's addition is applied last and the result saturated.
  always_comb begin
    w_ack_take  = (r_state == CH_OFFER) && i_ack;
    w_ack_rows  = w_ack_take ? r_rows : '0;
    w_net       = {1'b0, r_pending} - NW'(i_cancel) - NW'(w_ack_rows) + NW'(i_add);
    w_pend_next = (w_net > LP_MAXP) ? LP_MAXP[PEND_W-1:0] : w_net[PEND_W-1:0];
    w_burst     = (w_pend_next > LP_BURST) ? LP_BURST[ROWS_W-1:0] : w_pend_next[ROWS_W-1:0];
    w_enter     = i_step && (r_state == CH_IDLE) && i_lock && (w_pend_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= CH_IDLE;
      r_pending <= '0;
      r_rows    <= '0;
      r_hole    <= '0;
      r_valid   <= 1'b0;
    end else if (i_flush) begin
      r_state   <= CH_IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
    end else if (i_step) begin
      r_pending <= w_pend_next;
      if (w_enter) begin
        r_state <= CH_OFFER;
        r_valid <= 1'b1;
        r_rows  <= w_burst;
        r_hole  <= i_hole;
      end else if (w_ack_take) begin
        r_state <= CH_IDLE;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_rows    = r_rows;
  assign o_hole    = r_hole;
  assign o_pending = r_pending;
  assign o_offered = (r_state == CH_OFFER) ? PEND_W'(r_rows) : '0;
  assign o_enter   = w_enter;

endmodule

// File: rtl/garbage_arbiter.sv
// Versus-mode garbage arbiter: turns each player's line clears into attack
// rows, cancels them against the clearer's own pending garbage, queues the
// rest for the opponent and offers it at piece lock via valid/ack.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   enable                   match running; 0 freezes everything
//   clear_valid_N/lines_N    line-clear pulse and count (1..4)
//   lock_N, garbage_ack_N    piece-lock pulse, offer acknowledge
//   fail_N                   player topped out
//   garbage_valid/rows/hole_N  offer to player N
//   pending_N                rows owed to player N
//   over                     latched game-over
module garbage_arbiter
  import garbage_arbiter_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 20,
  parameter int unsigned MAX_BURST   = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear_valid_1,
  input  logic [2:0]        clear_lines_1,
  input  logic              lock_1,
  input  logic              garbage_ack_1,
  input  logic              fail_1,
  input  logic              clear_valid_2,
  input  logic [2:0]        clear_lines_2,
  input  logic              lock_2,
  input  logic              garbage_ack_2,
  input  logic              fail_2,
  output logic              garbage_valid_1,
  output logic [ROWS_W-1:0] garbage_rows_1,
  output logic [HOLE_W-1:0] garbage_hole_1,
  output logic [PEND_W-1:0] pending_1,
  output logic              garbage_valid_2,
  output logic [ROWS_W-1:0] garbage_rows_2,
  output logic [HOLE_W-1:0] garbage_hole_2,
  output logic [PEND_W-1:0] pending_2,
  output logic              over
);

  logic [7:0]        r_lfsr;
  logic              r_over;

  logic              w_run, w_step, w_flush;
  logic [ROWS_W-1:0] w_atk_1, w_atk_2;
  logic [PEND_W-1:0] w_offered_1, w_offered_2;
  logic [PEND_W-1:0] w_free_1, w_free_2;
  logic [ROWS_W-1:0] w_cancel_1, w_cancel_2;
  logic [ROWS_W-1:0] w_excess_1, w_excess_2;
  logic [7:0]        w_lfsr_n1;
  logic [HOLE_W-1:0] w_hole_1, w_hole_2;
  logic              w_enter_1, w_enter_2;

  // Cross-coupling: each clear first cancels the clearer's free (un-offered)
  // pending rows; the excess is sent to the opponent.
  always_comb begin
    w_run      = enable && !r_over;
    w_flush    = w_run && (fail_1 || fail_2);
    w_step     = w_run && !(fail_1 || fail_2);
    w_atk_1    = clear_valid_1 ? attack_rows(clear_lines_1) : '0;
    w_atk_2    = clear_valid_2 ? attack_rows(clear_lines_2) : '0;
    w_free_1   = pending_1 - w_offered_1;
    w_free_2   = pending_2 - w_offered_2;
    w_cancel_1 = (PEND_W'(w_atk_1) > w_free_1) ? w_free_1[ROWS_W-1:0] : w_atk_1;
    w_cancel_2 = (PEND_W'(w_atk_2) > w_free_2) ? w_free_2[ROWS_W-1:0] : w_atk_2;
    w_excess_1 = w_atk_1 - w_cancel_1;
    w_excess_2 = w_atk_2 - w_cancel_2;
    // Player 1 draws from the current LFSR value; player 2 from the next one
    // when both offers start together.
    w_lfsr_n1  = lfsr_step(r_lfsr);
    w_hole_1   = hole_of(r_lfsr);
    w_hole_2   = w_enter_1 ? hole_of(w_lfsr_n1) : hole_of(r_lfsr);
  end

  garbage_channel #(
    .MAX_PENDING (MAX_PENDING),
    .MAX_BURST   (MAX_BURST)
  ) u_ch_1 (
    .clk       (clk),
    .rst       (rst),
    .i_step    (w_step),
    .i_flush   (w_flush),
    .i_lock    (lock_1),
    .i_ack     (garbage_ack_1),
    .i_cancel  (w_cancel_1),
    .i_add     (w_excess_2),
    .i_hole    (w_hole_1),
    .o_valid   (garbage_valid_1),
    .o_rows    (garbage_rows_1),
    .o_hole    (garbage_hole_1),
    .o_pending (pending_1),
    .o_offered (w_offered_1),
    .o_enter   (w_enter_1)
  );

  garbage_channel #(
    .MAX_PENDING (MAX_PENDING),
    .MAX_BURST   (MAX_BURST)
  ) u_ch_2 (
    .clk       (clk),
    .rst       (rst),
    .i_step    (w_step),
    .i_flush   (w_flush),
    .i_lock    (lock_2),
    .i_ack     (garbage_ack_2),
    .i_cancel  (w_cancel_2),
    .i_add     (w_excess_1),
    .i_hole    (w_hole_2),
    .o_valid   (garbage_valid_2),
    .o_rows    (garbage_rows_2),
    .o_hole    (garbage_hole_2),
    .o_pending (pending_2),
    .o_offered (w_offered_2),
    .o_enter   (w_enter_2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
      r_over <= 1'b0;
    end else begin
      if (w_flush)
        r_over <= 1'b1;
      if (w_enter_1 && w_enter_2)
        r_lfsr <= lfsr_step(w_lfsr_n1);
      else if (w_enter_1 || w_enter_2)
        r_lfsr <= w_lfsr_n1;
    end
  end

  assign over = r_over;

endmodule

// File: tb/tb_garbage_arbiter.sv
module tb_garbage_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear_valid_1 = 1'b0, lock_1 = 1'b0, garbage_ack_1 = 1'b0, fail_1 = 1'b0;
  logic       clear_valid_2 = 1'b0, lock_2 = 1'b0, garbage_ack_2 = 1'b0, fail_2 = 1'b0;
  logic [2:0] clear_lines_1 = '0, clear_lines_2 = '0;
  logic       garbage_valid_1, garbage_valid_2, over;
  logic [2:0] garbage_rows_1, garbage_rows_2;
  logic [3:0] garbage_hole_1, garbage_hole_2;
  logic [4:0] pending_1, pending_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  garbage_arbiter #(
    .MAX_PENDING (20),
    .MAX_BURST   (4),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .clear_valid_1   (clear_valid_1),
    .clear_lines_1   (clear_lines_1),
    .lock_1          (lock_1),
    .garbage_ack_1   (garbage_ack_1),
    .fail_1          (fail_1),
    .clear_valid_2   (clear_valid_2),
    .clear_lines_2   (clear_lines_2),
    .lock_2          (lock_2),
    .garbage_ack_2   (garbage_ack_2),
    .fail_2          (fail_2),
    .garbage_valid_1 (garbage_valid_1),
    .garbage_rows_1  (garbage_rows_1),
    .garbage_hole_1  (garbage_hole_1),
    .pending_1       (pending_1),
    .garbage_valid_2 (garbage_valid_2),
    .garbage_rows_2  (garbage_rows_2),
    .garbage_hole_2  (garbage_hole_2),
    .pending_2       (pending_2),
    .over            (over)
  );

  typedef struct {
    int rst, en;
    int cv1, cl1, lk1, ak1, f1;
    int cv2, cl2, lk2, ak2, f2;
    int ev1, er1, eh1, ep1;
    int ev2, er2, eh2, ep2;
    int eov;
  } vec_t;

  function automatic vec_t V(int rst_i, int en,
                             int cv1, int cl1, int lk1, int ak1, int f1,
                             int cv2, int cl2, int lk2, int ak2, int f2,
                             int ev1, int er1, int eh1, int ep1,
                             int ev2, int er2, int eh2, int ep2, int eov);
    vec_t v;
    v.rst = rst_i; v.en = en;
    v.cv1 = cv1; v.cl1 = cl1; v.lk1 = lk1; v.ak1 = ak1; v.f1 = f1;
    v.cv2 = cv2; v.cl2 = cl2; v.lk2 = lk2; v.ak2 = ak2; v.f2 = f2;
    v.ev1 = ev1; v.er1 = er1; v.eh1 = eh1; v.ep1 = ep1;
    v.ev2 = ev2; v.er2 = er2; v.eh2 = eh2; v.ep2 = ep2;
    v.eov = eov;
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL vec %0d %s got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, check just after the next rising edge.
  // Rows/hole are only compared while an offer is expected, or at reset.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst           = v.rst[0];
    enable        = v.en[0];
    clear_valid_1 = v.cv1[0]; clear_lines_1 = 3'(v.cl1); lock_1 = v.lk1[0];
    garbage_ack_1 = v.ak1[0]; fail_1 = v.f1[0];
    clear_valid_2 = v.cv2[0]; clear_lines_2 = 3'(v.cl2); lock_2 = v.lk2[0];
    garbage_ack_2 = v.ak2[0]; fail_2 = v.f2[0];
    @(posedge clk);
    #1;
    chk(idx, "valid_1", int'(garbage_valid_1), v.ev1);
    chk(idx, "pending_1", int'(pending_1), v.ep1);
    chk(idx, "valid_2", int'(garbage_valid_2), v.ev2);
    chk(idx, "pending_2", int'(pending_2), v.ep2);
    chk(idx, "over", int'(over), v.eov);
    if (v.ev1 != 0 || v.rst == 0) begin
      chk(idx, "rows_1", int'(garbage_rows_1), v.er1);
      chk(idx, "hole_1", int'(garbage_hole_1), v.eh1);
    end
    if (v.ev2 != 0 || v.rst == 0) begin
      chk(idx, "rows_2", int'(garbage_rows_2), v.er2);
      chk(idx, "hole_2", int'(garbage_hole_2), v.eh2);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // LFSR from 0xA5: A5,4A,95,2A,54 -> holes 5,4,9,2,4
    //        rst en  cv1 cl1 lk1 ak1 f1  cv2 cl2 lk2 ak2 f2  v1 r1 h1 p1  v2 r2 h2 p2  ov
    tbl.push_back(V(0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,4,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,  1,4,5,4,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,2,0,0,0, 0,0,0,1,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,3,0,0,0, 0,0,0,3,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,1,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,0,0, 0,0,0,3,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,3,0,0,0, 0,0,0,5,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,2,0,0,0, 0,0,0,6,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,2,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,1,0,0,0, 0,0,0,0,0, 0,0,0,2,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,7,0,0,0, 0,0,0,2,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,5,0,0,0, 0,0,0,2,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,2,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,3,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,4,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,8,  0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,12, 0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,16, 0));
    tbl.push_back(V(1,1, 1,3,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,18, 0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,20, 0));
    tbl.push_back(V(1,1, 1,4,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,20, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,  1,4,4,20, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,  1,4,4,20, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,  0,0,0,16, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,  0,0,0,16, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,0,0, 0,0,0,0,  0,0,0,12, 0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,0,0, 0,0,0,0,  0,0,0,8,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,0,0, 0,0,0,0,  0,0,0,4,  0));
    tbl.push_back(V(1,1, 1,2,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,5,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,  1,4,9,5,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,1,0, 0,0,0,3,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,3,0,0,0, 0,0,0,0,0, 0,0,0,1,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,2,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 1,3,0,0,0, 1,3,0,0,0, 0,0,0,2,  0,0,0,2,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,4,0,0,0, 0,0,0,4,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,3,0,0,0, 0,0,0,6,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 1,2,0,0,0, 0,0,0,7,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,1,0,0, 0,0,0,0,0, 1,4,2,7,  0,0,0,0,  0));
    tbl.push_back(V(1,1, 0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,  0,0,0,0,  1));
    tbl.push_back(V(1,1, 1,4,1,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  1));
    tbl.push_back(V(1,1, 0,0,0,1,0, 1,4,1,0,0, 0,0,0,0,  0,0,0,0,  1));
    tbl.push_back(V(0,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(i, tbl[i]);

    // Both offers start together: P1 takes A5 (hole 5), P2 takes 4A (hole 4),
    // then a frozen cycle, a lock with nothing pending, and a lock whose
    // pending arrives in the same cycle (rows 1, hole from 0x95 -> 9).
    apply(100, V(1,1, 1,4,0,0,0, 1,4,0,0,0, 0,0,0,4,  0,0,0,4,  0));
    apply(101, V(1,1, 0,0,1,0,0, 0,0,1,0,0, 1,4,5,4,  1,4,4,4,  0));
    apply(102, V(1,0, 1,4,0,1,1, 0,0,1,1,0, 1,4,5,4,  1,4,4,4,  0));
    apply(103, V(1,1, 0,0,0,1,0, 0,0,0,0,0, 0,0,0,0,  1,4,4,4,  0));
    apply(104, V(1,1, 0,0,1,0,0, 0,0,0,0,0, 0,0,0,0,  1,4,4,4,  0));
    apply(105, V(1,1, 0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,  0,0,0,0,  0));
    apply(106, V(1,1, 0,0,1,0,0, 1,2,0,0,0, 1,1,9,1,  0,0,0,0,  0));
    apply(107, V(1,1, 0,0,0,1,0, 0,0,0,0,0, 0,0,0,0,  0,0,0,0,  0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/garbage_arbiter.md
Name: garbage_arbiter

Overview:
- Schedules "attack" garbage rows between the two tetris player instances in the versus game.
- Converts each player's line clears into garbage owed to the opponent.
- Cancels incoming garbage against outgoing garbage, and queues what remains per player.
- Offers garbage to a player's board only at piece-lock time, through a valid/ack handshake.
- Sits in top between player_1/player_2 and is the single owner of the pending-garbage counters shown on the display.

Parameters:
- MAX_PENDING, 20: saturation limit of each player's pending-garbage counter (rows).
- MAX_BURST, 4: maximum rows delivered in one offer.
- LFSR_SEED, 8'hA5: reset value of the 8-bit hole-column LFSR; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- enable  in  1  match running; 0 = frozen (sw[14] stop / pre-start)
- clear_valid_1  in  1  one-cycle pulse: player 1 cleared lines
- clear_lines_1  in  3  lines cleared by player 1, 1..4, valid with clear_valid_1
- lock_1  in  1  one-cycle pulse: player 1 piece locked, board may accept garbage
- garbage_ack_1  in  1  player 1 has inserted the offered rows
- fail_1  in  1  player 1 topped out (level)
- clear_valid_2 / clear_lines_2 / lock_2 / garbage_ack_2 / fail_2: same as above for player 2
- garbage_valid_1  out  1  offer pending to player 1
- garbage_rows_1  out  3  rows offered to player 1, 1..MAX_BURST
- garbage_hole_1  out  4  empty column of the offered rows, 0..9
- pending_1  out  5  rows currently owed to player 1, including the offered rows
- garbage_valid_2 / garbage_rows_2 / garbage_hole_2 / pending_2: same as above for player 2
- over  out  1  either player failed; latched

Behaviour:
- Reset (rst==0 at a clk edge): all pending = 0, valid = 0, rows = 0, hole = 0, over = 0, LFSR = LFSR_SEED, both channels in IDLE.
- Attack table, applied to clear_lines: 1->0, 2->1, 3->2, 4->4. Values 0 and 5..7 -> 0.
- Cancellation on clear_valid_N with attack a, registered in the same cycle:
  - free_N = pending_N - offered_N, where offered_N = garbage_rows_N if in OFFER, else 0.
  - c = min(a, free_N); pending_N -= c.
  - pending_opp += (a - c), saturating at MAX_PENDING.
- Simultaneous clears: both cancellations are computed from pre-edge values. Each player's pending is net of its own cancellation plus the opponent's addition, saturated.
- Per-player channel FSM, IDLE / OFFER:
  - IDLE -> OFFER on lock_N when enable && !over && pending_N > 0. At entry: rows = min(pending_N, MAX_BURST) using the post-update pending of that same cycle; hole = LFSR % 10. The LFSR advances one step.
  - OFFER: valid = 1; rows and hole are held stable until ack.
  - OFFER -> IDLE on garbage_ack_N: pending_N -= rows (never underflows, because offered rows cannot be cancelled); valid drops the next cycle.
  - Ack in the same cycle as a clear: the ack subtraction and the cancellation apply together; free_N uses the pre-ack offered value.
  - lock_N while in OFFER: ignored. Ack while in IDLE: ignored.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps only at offer entry, so the hole sequence is deterministic per seed.
- enable == 0: no counter or FSM changes, inputs are ignored, and outputs hold their values.
- fail_1 or fail_2 high with enable: over sets to 1 the next edge and holds until reset. In that same edge both pendings clear to 0, both channels go to IDLE and valid drops. Clears, locks and acks arriving in the fail cycle are discarded.
- Latency: clear -> pending update 1 cycle; lock -> valid 1 cycle; ack -> valid low 1 cycle.

Decomposition:
- Shared package (global.vh): attack table constants ATK_1..ATK_4, PEND_W = 5, ROWS_W = 3, HOLE_W = 4, state encodings CH_IDLE / CH_OFFER.
- Sub-module garbage_channel, instantiated twice: it owns one pending counter, the FSM and the offer registers, with cancel_req / add_req inputs from a top-level combinational cross-coupling block.
- LFSR stays in garbage_arbiter, shared by both channels. If both channels enter OFFER in the same cycle, player 1 takes the current LFSR value and player 2 takes the next value; the LFSR advances two steps.

Test Plan:
- Player 1 clears 4 (P2 pending 0) -> pending_2 = 4 next cycle. lock_2 -> valid_2 = 1, rows_2 = 4, hole_2 = (0xA5 step1) % 10. ack_2 -> pending_2 = 0, valid_2 = 0.
- pending_1 = 3, player 1 clears 4 -> pending_1 = 0, pending_2 = 1. Repeat with pending_1 = 6 -> pending_1 = 2, pending_2 unchanged.
- pending_2 = 18, player 1 clears 4 twice -> pending_2 saturates at 20. A lock then yields rows_2 = 4 and pending_2 = 16 after ack.
- Player 2 in OFFER with rows 4, pending_2 = 5, player 2 clears 4 same cycle as ack_2 -> c = 1, pending_2 = 0, pending_1 += 3.
- Both players clear 3 in the same cycle with pendings 0/0 -> pending_1 = 2, pending_2 = 2.
- fail_2 asserted while valid_1 = 1 and pending_1 = 7 -> next cycle over = 1, pending_1 = 0, valid_1 = 0. Later clears and locks have no effect. rst = 0 restores all reset values.
